// File: rtl/credit_sender.sv
// ---------------------------------------------------------------------------
// credit_sender
//
// Credit-based sender. Each word forwarded to the receiver consumes one
// credit; each credit_in pulse returns one. Upstream words are accepted only
// while credits are available and the block is in RUN. A flush request moves
// the block into DRAIN, where no new words are accepted until every credit
// has come back, after which flush_done pulses and the block returns to RUN.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     upstream word available
//   in_ready     word accepted this cycle (combinational)
//   in_data      upstream word
//   out_valid    one-cycle send strobe to the receiver (no back-pressure)
//   out_data     registered word sent to the receiver
//   credit_in    one-cycle pulse, receiver freed one buffer slot
//   flush        drain request, sampled only in RUN
//   flush_done   one-cycle pulse, drain complete
//   credits      current available credit count
//   err_overflow sticky, a credit arrived while the count was already full
// ---------------------------------------------------------------------------
module credit_sender #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int MAX_CREDITS = 8,
    localparam int CNT_WIDTH   = $clog2(MAX_CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  credit_in,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [CNT_WIDTH-1:0]  credits,
    output logic                  err_overflow
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_CREDITS);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    credits_q, credits_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    err_q, err_d;

    logic                    transfer;
    logic                    at_max;
    logic [CNT_WIDTH-1:0]    delta;

    // Reset leaves the count full in RUN, so in_ready reads high during reset;
    // the held flops guarantee nothing is actually accepted.
    assign in_ready = (state_q == RUN) && (credits_q != '0);
    assign transfer = in_valid && in_ready;
    assign at_max   = (credits_q == MAX_CNT);

    always_comb begin
        state_d     = state_q;
        flush_done  = 1'b0;
        delta       = '0;
        out_valid_d = transfer;
        out_data_d  = transfer ? in_data : out_data_q;
        err_d       = err_q;

        // Single adder on the registered count; -1 is the all-ones addend.
        // A returned credit on a full count is dropped and flagged instead.
        unique case ({credit_in, transfer})
            2'b10: begin
                if (at_max) begin
                    err_d = 1'b1;
                end else begin
                    delta = CNT_WIDTH'(1);
                end
            end
            2'b01:   delta = '1;
            default: delta = '0;
        endcase
        credits_d = credits_q + delta;

        unique case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Decided on the registered count: a credit arriving in this
                // same cycle is an overflow, handled above.
                if (at_max) begin
                    flush_done = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            credits_q   <= MAX_CNT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            credits_q   <= credits_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign credits      = credits_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_credit_sender.sv
module tb_credit_sender;

    localparam int DW  = 32;
    localparam int MAX = 8;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          credit_in = 1'b0;
    logic          flush = 1'b0;
    logic          flush_done;
    logic [CW-1:0] credits;
    logic          err_overflow;

    credit_sender #(.DATA_WIDTH(DW), .MAX_CREDITS(MAX)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .credit_in(credit_in), .flush(flush), .flush_done(flush_done),
        .credits(credits), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: an integer credit pool, a draining flag and the
    // last word sent, updated once per clock from the rules of the block.
    int        m_credits = MAX;
    bit        m_drain   = 0;
    bit        m_err     = 0;
    bit        m_ov      = 0;
    bit [DW-1:0] m_od    = '0;

    function automatic bit m_ready();
        return !m_drain && (m_credits > 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_credits = MAX; m_drain = 0; m_err = 0; m_ov = 0; m_od = '0;
        end else begin
            bit xfer;
            int pre;
            xfer = in_valid && m_ready();
            pre  = m_credits;
            if (m_drain) begin
                if (pre == MAX) m_drain = 0;
            end else if (flush) begin
                m_drain = 1;
            end
            if (credit_in && !xfer) begin
                if (pre == MAX) m_err = 1;
                else m_credits = pre + 1;
            end else if (xfer && !credit_in) begin
                m_credits = pre - 1;
            end
            m_ov = xfer;
            if (xfer) m_od = in_data;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("in_ready",     64'(in_ready),     64'(m_ready()));
        chk("credits",      64'(credits),      64'(m_credits));
        chk("out_valid",    64'(out_valid),    64'(m_ov));
        chk("out_data",     64'(out_data),     64'(m_od));
        chk("flush_done",   64'(flush_done),   64'(m_drain && m_credits == MAX));
        chk("err_overflow", 64'(err_overflow), 64'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        repeat (3) step();
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_credits",  64'(credits),  64'd8);
        rst = 1'b0;

        // Streaming from a full pool: exactly 8 sends, then stalled at zero.
        in_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            in_data = $urandom;
            step();
            if (out_valid) cnt++;
        end
        chk("burst_pulses",   64'(cnt),      64'd8);
        chk("burst_credits",  64'(credits),  64'd0);
        chk("burst_in_ready", 64'(in_ready), 64'd0);

        // One credit with in_valid high: one more word then empty again.
        credit_in = 1'b1; in_data = 32'hCAFE_0001;
        step();
        credit_in = 1'b0;
        chk("one_credit_cnt", 64'(credits), 64'd1);
        step();
        chk("one_credit_zero", 64'(credits),  64'd0);
        chk("one_credit_data", 64'(out_data), 64'hCAFE_0001);

        // credits == 1, send and credit in the same cycle.
        in_valid = 1'b0; credit_in = 1'b1;
        step();
        in_valid = 1'b1;
        step();
        credit_in = 1'b0; in_valid = 1'b0;
        chk("simul_credits",  64'(credits),  64'd1);
        chk("simul_in_ready", 64'(in_ready), 64'd1);

        // Refill to full, then one extra credit raises the sticky error.
        credit_in = 1'b1;
        repeat (7) step();
        chk("refill_credits", 64'(credits), 64'd8);
        step();
        credit_in = 1'b0;
        chk("ovf_credits", 64'(credits),      64'd8);
        chk("ovf_flag",    64'(err_overflow), 64'd1);
        repeat (3) step();
        chk("ovf_sticky",  64'(err_overflow), 64'd1);

        // Drain from 5 credits.
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        chk("pre_flush_credits", 64'(credits), 64'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("drain_in_ready", 64'(in_ready), 64'd0);
        cnt = 0;
        credit_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (flush_done) cnt++;
            step();
        end
        credit_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (flush_done) cnt++;
            step();
        end
        chk("flush_done_count", 64'(cnt),      64'd1);
        chk("post_drain_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of a drain with 6 credits.
        in_valid = 1'b1;
        repeat (2) step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("mid_drain_credits", 64'(credits), 64'd6);
        #2 rst = 1'b1;
        #1;
        chk("arst_credits",    64'(credits),      64'd8);
        chk("arst_out_valid",  64'(out_valid),    64'd0);
        chk("arst_flush_done", 64'(flush_done),   64'd0);
        chk("arst_in_ready",   64'(in_ready),     64'd1);
        chk("arst_err",        64'(err_overflow), 64'd0);
        step();
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            credit_in = ($urandom_range(0, 99) < 30);
            flush     = ($urandom_range(0, 99) < 5);
            in_data   = $urandom;
            rst       = ($urandom_range(0, 999) < 4);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; credit_in = 1'b0; flush = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
